// File: rtl/datapath_pkg.sv
// Shared encodings for the multicycle load/store/ALU datapath.
package datapath_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADDI  = 3'b010,
        OP_SUBI  = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_AND   = 3'b110,
        OP_OR    = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MEM  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/reg_file_p.sv
// Register file: two operand reads, two debug reads, one synchronous write.
// Entry 0 is never written, so it always reads zero.
module reg_file_p #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    localparam int unsigned RAW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RAW-1:0]  ra,
    input  logic [RAW-1:0]  rb,
    output logic [XLEN-1:0] douta,
    output logic [XLEN-1:0] doutb,
    input  logic [RAW-1:0]  dbg_a,
    input  logic [RAW-1:0]  dbg_b,
    output logic [XLEN-1:0] dbg_douta,
    output logic [XLEN-1:0] dbg_doutb,
    input  logic            we,
    input  logic [RAW-1:0]  wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign douta     = regs[ra];
    assign doutb     = regs[rb];
    assign dbg_douta = regs[dbg_a];
    assign dbg_doutb = regs[dbg_b];

endmodule

// File: rtl/datapath_mc.sv
// Multicycle load/store/ALU datapath: IDLE -> EXEC -> {MEM, WB, DONE} sequencing
// around a 2R1W register file and a req/ack data-memory port.
module datapath_mc
    import datapath_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned MEM_AW = 10,
    localparam int unsigned RAW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [2:0]        op,
    input  logic [RAW-1:0]    ra,
    input  logic [RAW-1:0]    rb,
    input  logic [RAW-1:0]    rw,
    input  logic [XLEN-1:0]   imm,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic [RAW-1:0]    dbg_a,
    input  logic [RAW-1:0]    dbg_b,
    output logic [XLEN-1:0]   dbg_douta,
    output logic [XLEN-1:0]   dbg_doutb
);

    state_e          state, state_nx;
    op_e             op_q;
    logic [RAW-1:0]  ra_q, rb_q, rw_q;
    logic [XLEN-1:0] imm_q, result_q;
    logic [XLEN-1:0] rd_a, rd_b;
    logic [XLEN-1:0] opnd_y, alu_res, ea;
    logic            alu_ovf, ea_bad, is_mem, wb_en;

    reg_file_p #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra_q),
        .rb        (rb_q),
        .douta     (rd_a),
        .doutb     (rd_b),
        .dbg_a     (dbg_a),
        .dbg_b     (dbg_b),
        .dbg_douta (dbg_douta),
        .dbg_doutb (dbg_doutb),
        .we        (wb_en),
        .wa        (rw_q),
        .wd        (result_q)
    );

    // Operand x is always reg[rb]; y is imm for the immediate forms, else reg[ra].
    always_comb begin
        opnd_y  = (op_q == OP_ADDI || op_q == OP_SUBI) ? imm_q : rd_a;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDI: begin
                alu_res = rd_b + opnd_y;
                alu_ovf = (rd_b[XLEN-1] == opnd_y[XLEN-1]) && (alu_res[XLEN-1] != rd_b[XLEN-1]);
            end
            OP_SUB, OP_SUBI: begin
                alu_res = rd_b - opnd_y;
                alu_ovf = (rd_b[XLEN-1] != opnd_y[XLEN-1]) && (alu_res[XLEN-1] != rd_b[XLEN-1]);
            end
            OP_AND:  alu_res = rd_b & rd_a;
            OP_OR:   alu_res = rd_b | rd_a;
            default: ;
        endcase
        ea     = rd_b + imm_q;
        ea_bad = (ea >> MEM_AW) != '0;
        is_mem = (op_q == OP_LOAD) || (op_q == OP_STORE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        done     = 1'b0;
        mem_req  = 1'b0;
        wb_en    = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (!is_mem)     state_nx = S_WB;
                else if (ea_bad) state_nx = S_DONE;
                else             state_nx = S_MEM;
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) state_nx = (op_q == OP_LOAD) ? S_WB : S_DONE;
            end
            S_WB: begin
                wb_en    = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= OP_LOAD;
            ra_q      <= '0;
            rb_q      <= '0;
            rw_q      <= '0;
            imm_q     <= '0;
            result_q  <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q  <= op_e'(op);
                    ra_q  <= ra;
                    rb_q  <= rb;
                    rw_q  <= rw;
                    imm_q <= imm;
                    err   <= 1'b0;
                    ovf   <= 1'b0;
                end
                S_EXEC: begin
                    if (is_mem) begin
                        err <= ea_bad;
                        if (!ea_bad) begin
                            mem_addr  <= ea[MEM_AW-1:0];
                            mem_we    <= (op_q == OP_STORE);
                            mem_wdata <= rd_a;
                        end
                    end else begin
                        result_q <= alu_res;
                        ovf      <= alu_ovf;
                    end
                end
                S_MEM:  if (mem_ack && op_q == OP_LOAD) result_q <= mem_rdata;
                S_DONE: mem_we <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc with a word-array memory model and programmable ack delay.
module tb_datapath_mc;
    import datapath_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic [2:0]  op;
    logic [4:0]  ra, rb, rw;
    logic [63:0] imm;
    logic        done, err, ovf;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [4:0]  dbg_a, dbg_b;
    logic [63:0] dbg_douta, dbg_doutb;

    int nvec = 0;
    int nerr = 0;

    logic [63:0] mem [1024];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          req_cnt   = 0;
    logic [9:0]  last_addr;
    logic [63:0] last_wdata;
    logic        last_we;

    datapath_mc #(.XLEN(64), .NREGS(32), .MEM_AW(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ready     (ready),
        .op        (op),
        .ra        (ra),
        .rb        (rb),
        .rw        (rw),
        .imm       (imm),
        .done      (done),
        .err       (err),
        .ovf       (ovf),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .dbg_a     (dbg_a),
        .dbg_b     (dbg_b),
        .dbg_douta (dbg_douta),
        .dbg_doutb (dbg_doutb)
    );

    always #5 clk = ~clk;

    // Ack is raised on the (ack_delay+1)-th cycle of a request.
    always @(negedge clk) begin
        if (mem_req) begin
            req_cnt++;
            if (wait_cnt == ack_delay) begin
                mem_ack    = 1'b1;
                mem_rdata  = mem[mem_addr];
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
                last_we    = mem_we;
                if (mem_we) mem[mem_addr] = mem_wdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end
            wait_cnt++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            wait_cnt  = 0;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic rd_reg(input logic [4:0] idx, output logic [63:0] val);
        dbg_a = idx;
        #1;
        val = dbg_douta;
    endtask

    // Latency counts cycles after the accepting edge; cycle k+1 reports 1.
    task automatic run_op(input logic [2:0] o, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] w, input logic [63:0] im, input int dly,
                          output int lat, output logic e, output logic v);
        ack_delay = dly;
        @(negedge clk);
        op = o; ra = a; rb = b; rw = w; imm = im;
        start = 1'b1;
        req_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = err;
        v = ovf;
    endtask

    int          lat;
    logic        e, v;
    logic [63:0] r;
    int          ndone;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[1023] = 64'h1234;
        mem[9]    = 64'h55;
        rst_n = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rw = '0; imm = '0;
        dbg_a = '0; dbg_b = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", ready, 1);
        check_val("rst_done", done, 0);
        check_val("rst_errovf", {err, ovf}, 0);
        check_val("rst_memreq", {mem_req, mem_we}, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        rd_reg(5'd15, r); check_val("rst_reg15", r, 0);
        rst_n = 1'b1;

        run_op(OP_ADDI, 0, 0, 15, -64'sd85, 0, lat, e, v);
        check_val("addi_lat", lat, 3);
        check_val("addi_errovf", {e, v}, 0);
        rd_reg(5'd15, r); check_val("addi_r15", r, -64'sd85);

        run_op(OP_ADDI, 0, 0, 16, 64'd42, 0, lat, e, v);
        run_op(OP_SUB, 16, 15, 17, 0, 0, lat, e, v);
        check_val("sub_ovf", v, 0);
        rd_reg(5'd17, r); check_val("sub_r17", r, -64'sd127);

        run_op(OP_ADDI, 0, 0, 18, 64'h7FFF_FFFF_FFFF_FFFF, 0, lat, e, v);
        check_val("addi_max_ovf", v, 0);
        run_op(OP_ADDI, 0, 0, 19, 64'd1, 0, lat, e, v);
        run_op(OP_ADD, 19, 18, 20, 0, 0, lat, e, v);
        check_val("add_ovf", v, 1);
        check_val("add_lat", lat, 3);
        rd_reg(5'd20, r); check_val("add_r20", r, 64'h8000_0000_0000_0000);
        run_op(OP_SUBI, 0, 20, 21, 64'd1, 0, lat, e, v);
        check_val("subi_ovf", v, 1);
        rd_reg(5'd21, r); check_val("subi_r21", r, 64'h7FFF_FFFF_FFFF_FFFF);
        run_op(OP_AND, 16, 15, 22, 0, 0, lat, e, v);
        rd_reg(5'd22, r); check_val("and_r22", r, 64'd42);
        run_op(OP_OR, 19, 16, 23, 0, 0, lat, e, v);
        check_val("or_ovf", v, 0);
        rd_reg(5'd23, r); check_val("or_r23", r, 64'd43);

        run_op(OP_STORE, 17, 0, 0, 64'd8, 2, lat, e, v);
        check_val("st_lat", lat, 5);
        check_val("st_reqcnt", req_cnt, 3);
        check_val("st_addr", last_addr, 8);
        check_val("st_wdata", last_wdata, -64'sd127);
        check_val("st_we", last_we, 1);
        check_val("st_mem8", mem[8], -64'sd127);
        check_val("st_err", e, 0);

        run_op(OP_LOAD, 0, 0, 3, 64'd8, 0, lat, e, v);
        check_val("ld_lat", lat, 4);
        check_val("ld_we", last_we, 0);
        rd_reg(5'd3, r); check_val("ld_r3", r, -64'sd127);
        run_op(OP_LOAD, 0, 0, 4, 64'd1023, 1, lat, e, v);
        check_val("ld_top_err", e, 0);
        check_val("ld_top_lat", lat, 5);
        rd_reg(5'd4, r); check_val("ld_top_r4", r, 64'h1234);
        run_op(OP_LOAD, 0, 16, 6, -64'sd34, 0, lat, e, v);
        rd_reg(5'd6, r); check_val("ld_base_r6", r, -64'sd127);

        run_op(OP_LOAD, 0, 0, 5, -64'sd1, 0, lat, e, v);
        check_val("ld_neg_err", e, 1);
        check_val("ld_neg_lat", lat, 2);
        check_val("ld_neg_req", req_cnt, 0);
        run_op(OP_LOAD, 0, 0, 5, 64'd1024, 0, lat, e, v);
        check_val("ld_big_err", e, 1);
        check_val("ld_big_req", req_cnt, 0);
        rd_reg(5'd5, r); check_val("ld_err_r5", r, 0);

        run_op(OP_ADDI, 0, 0, 0, 64'd5, 0, lat, e, v);
        check_val("r0_lat", lat, 3);
        rd_reg(5'd0, r); check_val("r0_zero", r, 0);

        // Hold start through the busy cycles with a different request.
        @(negedge clk);
        op = OP_ADDI; ra = 0; rb = 0; rw = 7; imm = 64'd7; start = 1'b1;
        @(negedge clk);
        rw = 8; imm = 64'd9;
        ndone = 0;
        for (int i = 0; i < 2; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check_val("busy_ndone", ndone, 1);
        rd_reg(5'd7, r); check_val("busy_r7", r, 7);
        rd_reg(5'd8, r); check_val("busy_r8", r, 0);

        ack_delay = 3;
        @(negedge clk);
        op = OP_LOAD; ra = 0; rb = 0; rw = 9; imm = 64'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("mid_req", mem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_req_drop", mem_req, 0);
        check_val("mid_ready", ready, 1);
        rd_reg(5'd9, r); check_val("mid_r9", r, 0);
        rd_reg(5'd15, r); check_val("mid_r15_clr", r, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_val("post_done", done, 0);
        rd_reg(5'd9, r); check_val("post_r9", r, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
